// File: rtl/ft_freeze_sched_pkg.sv
// Shared encodings and default latencies for the freeze-time scheduler.
package ft_freeze_sched_pkg;

  // Per-bus latency tracker state.
  typedef enum logic {
    TRK_IDLE   = 1'b0,
    TRK_ACTIVE = 1'b1
  } trk_state_e;

  // Identifies the bus that won the most recent contested arbitration.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  // Default emulated latencies, in system cycles.
  localparam int FT_RD_LAT = 20;
  localparam int FT_WR_LAT = 24;

endpackage

// File: rtl/ft_lat_tracker.sv
// Measures the native latency of one Wishbone bus and holds the resulting
// freeze deficit in a one-entry pend register until the scheduler takes it.
//
// Pend/grant handshake: pend_valid is the offer and grant is the acceptance.
// The entry transfers in any cycle where both are high. Once valid is set it
// stays set, and its deficit can only grow, until the cycle it is granted.
module ft_lat_tracker
  import ft_freeze_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             hold,
  input  logic             read,
  input  logic             write,
  input  logic             stall,
  input  logic [CNT_W-1:0] cfg_rd_lat,
  input  logic [CNT_W-1:0] cfg_wr_lat,
  input  logic             grant,
  output logic             pend_valid,
  output logic [CNT_W-1:0] pend_deficit,
  output logic             done,
  output logic             active
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  trk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_deficit_q, pend_deficit_d;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] deficit;
  logic [CNT_W:0]   pend_sum;
  logic             new_deficit;

  // State, latency counter and pend register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= TRK_IDLE;
      cnt_q          <= '0;
      is_wr_q        <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_deficit_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_wr_q        <= is_wr_d;
      pend_valid_q   <= pend_valid_d;
      pend_deficit_q <= pend_deficit_d;
    end
  end

  // Next state: everything stands still while the system clock is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    if (!enable) begin
      state_d = TRK_IDLE;
      cnt_d   = '0;
    end else if (!hold) begin
      case (state_q)
        TRK_IDLE: begin
          if (read || write) begin
            state_d = TRK_ACTIVE;
            is_wr_d = write;
            cnt_d   = CNT_W'(1);
          end
        end
        TRK_ACTIVE: begin
          if (stall) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          end else if (read || write) begin
            // Back-to-back transaction starts in the completion cycle.
            is_wr_d = write;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = TRK_IDLE;
          end
        end
        default: state_d = TRK_IDLE;
      endcase
    end
  end

  // Outputs: completion strobe and the deficit against the configured latency.
  always_comb begin
    done    = enable && !hold && (state_q == TRK_ACTIVE) && !stall;
    target  = is_wr_q ? cfg_wr_lat : cfg_rd_lat;
    deficit = (target > cnt_q) ? (target - cnt_q) : '0;
    active  = (state_q == TRK_ACTIVE);
  end

  // Pend register: accumulate unserved deficits, saturating.
  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_deficit_d = pend_deficit_q;
    new_deficit    = done && (deficit != '0);
    pend_sum       = {1'b0, pend_deficit_q} + {1'b0, deficit};
    if (!enable) begin
      pend_valid_d   = 1'b0;
      pend_deficit_d = '0;
    end else if (grant) begin
      // Granted entry leaves; a deficit arriving now becomes the new entry.
      pend_valid_d   = new_deficit;
      pend_deficit_d = new_deficit ? deficit : '0;
    end else if (new_deficit) begin
      pend_valid_d = 1'b1;
      if (pend_valid_q) begin
        pend_deficit_d = pend_sum[CNT_W] ? CNT_MAX : pend_sum[CNT_W-1:0];
      end else begin
        pend_deficit_d = deficit;
      end
    end
  end

  assign pend_valid   = pend_valid_q;
  assign pend_deficit = pend_deficit_q;

endmodule

// File: rtl/ft_freeze_sched.sv
// Freeze-time scheduler: serializes instruction- and data-bus latency deficits
// through one freeze counter and drives the system clock-enable gate.
module ft_freeze_sched
  import ft_freeze_sched_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int STAT_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  cfg_rd_lat,
  input  logic [CNT_W-1:0]  cfg_wr_lat,
  input  logic              i_read,
  input  logic              i_write,
  input  logic              i_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic              d_stall,
  output logic              freeze,
  output logic              busy,
  output logic [STAT_W-1:0] txn_count,
  output logic [STAT_W-1:0] freeze_total
);

  logic             i_pend_valid, d_pend_valid;
  logic [CNT_W-1:0] i_pend_deficit, d_pend_deficit;
  logic             i_done, d_done;
  logic             i_active, d_active;
  logic             i_grant, d_grant;
  logic             grant_ok;

  gnt_e              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              freeze_q, freeze_d;
  logic [STAT_W-1:0] txn_count_q, txn_count_d;
  logic [STAT_W-1:0] freeze_total_q, freeze_total_d;

  ft_lat_tracker #(.CNT_W(CNT_W)) u_trk_i (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .hold         (freeze_q),
    .read         (i_read),
    .write        (i_write),
    .stall        (i_stall),
    .cfg_rd_lat   (cfg_rd_lat),
    .cfg_wr_lat   (cfg_wr_lat),
    .grant        (i_grant),
    .pend_valid   (i_pend_valid),
    .pend_deficit (i_pend_deficit),
    .done         (i_done),
    .active       (i_active)
  );

  ft_lat_tracker #(.CNT_W(CNT_W)) u_trk_d (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .hold         (freeze_q),
    .read         (d_read),
    .write        (d_write),
    .stall        (d_stall),
    .cfg_rd_lat   (cfg_rd_lat),
    .cfg_wr_lat   (cfg_wr_lat),
    .grant        (d_grant),
    .pend_valid   (d_pend_valid),
    .pend_deficit (d_pend_deficit),
    .done         (d_done),
    .active       (d_active)
  );

  // Scheduler registers and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q   <= GNT_D;
      fcnt_q         <= '0;
      freeze_q       <= 1'b0;
      txn_count_q    <= '0;
      freeze_total_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      fcnt_q         <= fcnt_d;
      freeze_q       <= freeze_d;
      txn_count_q    <= txn_count_d;
      freeze_total_q <= freeze_total_d;
    end
  end

  // Round-robin arbitration. Granting at fcnt==1 lets the next deficit follow
  // the current one with no gap. last_grant only moves on a contested grant,
  // so an uncontested grant does not steal the other bus's turn.
  always_comb begin
    grant_ok     = enable && (fcnt_q <= CNT_W'(1));
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    last_grant_d = last_grant_q;
    if (grant_ok) begin
      if (i_pend_valid && d_pend_valid) begin
        if (last_grant_q == GNT_D) begin
          i_grant      = 1'b1;
          last_grant_d = GNT_I;
        end else begin
          d_grant      = 1'b1;
          last_grant_d = GNT_D;
        end
      end else if (i_pend_valid) begin
        i_grant = 1'b1;
      end else if (d_pend_valid) begin
        d_grant = 1'b1;
      end
    end
  end

  // Freeze counter: load on grant, otherwise count down to zero.
  always_comb begin
    fcnt_d = fcnt_q;
    if (!enable) begin
      fcnt_d = '0;
    end else if (i_grant) begin
      fcnt_d = i_pend_deficit;
    end else if (d_grant) begin
      fcnt_d = d_pend_deficit;
    end else if (fcnt_q != '0) begin
      fcnt_d = fcnt_q - CNT_W'(1);
    end
    freeze_d = (fcnt_d != '0);
  end

  // Statistics; both wrap and hold while bypassed.
  always_comb begin
    txn_count_d    = txn_count_q + STAT_W'(i_done) + STAT_W'(d_done);
    freeze_total_d = freeze_total_q;
    if (enable && freeze_q) freeze_total_d = freeze_total_q + STAT_W'(1);
  end

  assign freeze       = freeze_q;
  assign busy         = i_active || d_active || i_pend_valid || d_pend_valid ||
                        (fcnt_q != '0);
  assign txn_count    = txn_count_q;
  assign freeze_total = freeze_total_q;

endmodule

// File: tb/tb_ft_freeze_sched.sv
// Directed bench for ft_freeze_sched: latency deficits, arbitration order,
// accumulation, reset mid-freeze, bypass and counter saturation.
module tb_ft_freeze_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] cfg_rd_lat, cfg_wr_lat;
  logic [3:0]  cfg4_rd_lat, cfg4_wr_lat;
  logic        i_read, i_write, i_stall;
  logic        d_read, d_write, d_stall;
  logic        freeze, busy;
  logic [31:0] txn_count, freeze_total;
  logic        freeze4, busy4;
  logic [31:0] txn_count4, freeze_total4;

  int n_assert = 0;
  int n_fail   = 0;
  int first, len, runs;

  ft_freeze_sched #(.CNT_W(16), .STAT_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .cfg_rd_lat   (cfg_rd_lat),
    .cfg_wr_lat   (cfg_wr_lat),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_stall      (i_stall),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_stall      (d_stall),
    .freeze       (freeze),
    .busy         (busy),
    .txn_count    (txn_count),
    .freeze_total (freeze_total)
  );

  // Narrow-counter instance for the saturation case.
  ft_freeze_sched #(.CNT_W(4), .STAT_W(32)) dut4 (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .cfg_rd_lat   (cfg4_rd_lat),
    .cfg_wr_lat   (cfg4_wr_lat),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_stall      (i_stall),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_stall      (d_stall),
    .freeze       (freeze4),
    .busy         (busy4),
    .txn_count    (txn_count4),
    .freeze_total (freeze_total4)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one transaction per bus (start < 0 disables that bus). The
  // transaction opens at cycle 'start', stalls 'stalls' cycles and completes
  // on the next. With 'rst' set a 1-cycle transaction restarts in the
  // completion cycle. Returns just after the last completion edge.
  task automatic run_two(input int is, input int ist, input bit iw, input bit ir,
                         input int ds, input int dst, input bit dw, input bit dr);
    int ic, dc, last;
    ic   = (is >= 0) ? is + ist + 1 : -10;
    dc   = (ds >= 0) ? ds + dst + 1 : -10;
    last = ic + (ir ? 1 : 0);
    if (dc + (dr ? 1 : 0) > last) last = dc + (dr ? 1 : 0);
    for (int c = 0; c <= last; c++) begin
      i_read  = !iw && ((c == is) || (ir && c == ic));
      i_write =  iw && ((c == is) || (ir && c == ic));
      i_stall = (is >= 0) && (c > is) && (c < ic);
      d_read  = !dw && ((c == ds) || (dr && c == dc));
      d_write =  dw && ((c == ds) || (dr && c == dc));
      d_stall = (ds >= 0) && (c > ds) && (c < dc);
      step();
    end
    i_read = 0; i_write = 0; i_stall = 0;
    d_read = 0; d_write = 0; d_stall = 0;
  endtask

  // Samples freeze for n cycles: index of first high cycle, high count, runs.
  task automatic watch(input int n, input bit use4, output int f_first,
                       output int f_len, output int f_runs);
    logic f, prev;
    f_first = -1; f_len = 0; f_runs = 0; prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      f = use4 ? freeze4 : freeze;
      if (f) begin
        f_len++;
        if (f_first < 0) f_first = k;
        if (!prev) f_runs++;
      end
      prev = f;
      step();
    end
  endtask

  initial begin
    reset = 1; enable = 1;
    cfg_rd_lat = 16'd20; cfg_wr_lat = 16'd24;
    cfg4_rd_lat = 4'd15; cfg4_wr_lat = 4'd15;
    i_read = 0; i_write = 0; i_stall = 0;
    d_read = 0; d_write = 0; d_stall = 0;
    step(); step();
    check("rst_freeze", freeze, 0);
    check("rst_busy", busy, 0);
    check("rst_txn", txn_count, 0);
    check("rst_ftot", freeze_total, 0);
    reset = 0;
    step();

    // I read, native 5, read latency 20 -> 15 freeze cycles.
    run_two(0, 4, 0, 0, -1, 0, 0, 0);
    check("t1_txn", txn_count, 1);
    check("t1_busy", busy, 1);
    watch(25, 0, first, len, runs);
    check("t1_first", first, 1);
    check("t1_len", len, 15);
    check("t1_runs", runs, 1);
    check("t1_ftot", freeze_total, 15);
    check("t1_idle", busy, 0);

    // D write, native 30 over write latency 24 -> no freeze.
    run_two(-1, 0, 0, 0, 0, 29, 1, 0);
    check("t2_txn", txn_count, 2);
    check("t2_busy", busy, 0);
    watch(5, 0, first, len, runs);
    check("t2_len", len, 0);
    check("t2_ftot", freeze_total, 15);

    // Tie: I deficit 10, D deficit 6; first tie goes to I.
    run_two(8, 9, 0, 0, 0, 17, 1, 0);
    step();
    check("t3_i_taken", dut.i_pend_valid, 0);
    check("t3_d_wait", dut.d_pend_valid, 1);
    check("t3_fcnt", dut.fcnt_q, 10);
    watch(30, 0, first, len, runs);
    check("t3_first", first, 0);
    check("t3_len", len, 16);
    check("t3_runs", runs, 1);
    check("t3_txn", txn_count, 4);

    // Same tie again; now D goes first.
    run_two(8, 9, 0, 0, 0, 17, 1, 0);
    step();
    check("t3b_i_wait", dut.i_pend_valid, 1);
    check("t3b_d_taken", dut.d_pend_valid, 0);
    check("t3b_fcnt", dut.fcnt_q, 6);
    watch(30, 0, first, len, runs);
    check("t3b_len", len, 16);
    check("t3b_runs", runs, 1);
    check("t3b_ftot", freeze_total, 47);

    // I deficit 8, restart with 1-cycle read (deficit 19) -> 27 contiguous.
    run_two(0, 11, 0, 1, -1, 0, 0, 0);
    check("t4_txn", txn_count, 8);
    check("t4_pend", dut.i_pend_deficit, 19);
    check("t4_freeze", freeze, 1);
    watch(40, 0, first, len, runs);
    check("t4_first", first, 0);
    check("t4_len", len, 27);
    check("t4_runs", runs, 1);

    // Tie (I wins), D restarts while waiting: 4 + 23 accumulate to 27.
    run_two(5, 14, 0, 0, 0, 19, 1, 1);
    check("t4b_d_valid", dut.d_pend_valid, 1);
    check("t4b_d_accum", dut.d_pend_deficit, 27);
    watch(50, 0, first, len, runs);
    check("t4b_len", len, 32);
    check("t4b_runs", runs, 1);
    check("t4b_txn", txn_count, 11);
    check("t4b_ftot", freeze_total, 106);

    // Reset with fcnt=8 and D pend waiting.
    run_two(0, 7, 0, 0, 5, 3, 1, 0);
    step(); step(); step(); step();
    check("t5_fcnt", dut.fcnt_q, 8);
    check("t5_d_wait", dut.d_pend_valid, 1);
    reset = 1;
    step();
    check("t5_freeze", freeze, 0);
    check("t5_txn", txn_count, 0);
    check("t5_ftot", freeze_total, 0);
    check("t5_busy", busy, 0);
    reset = 0;
    watch(30, 0, first, len, runs);
    check("t5_len", len, 0);

    // Bypass while I is ACTIVE with cnt=3.
    i_read = 1; step();
    i_read = 0; i_stall = 1; step(); step();
    check("t6_cnt", dut.u_trk_i.cnt_q, 3);
    check("t6_active", dut.i_active, 1);
    enable = 0; step();
    check("t6_idle", dut.i_active, 0);
    enable = 1; i_stall = 0; step();
    watch(10, 0, first, len, runs);
    check("t6_len", len, 0);
    check("t6_txn", txn_count, 0);
    check("t6_busy", busy, 0);

    // 4-bit counter saturates at 15 after 20 stalls; latency 15 -> no deficit.
    run_two(0, 20, 0, 0, -1, 0, 0, 0);
    check("t7_sat", dut4.u_trk_i.cnt_q, 15);
    check("t7_txn4", txn_count4, 1);
    check("t7_wide_cnt", dut.u_trk_i.cnt_q, 21);
    watch(12, 1, first, len, runs);
    check("t7_len4", len, 0);
    check("t7_busy4", busy4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
